// File: rtl/mac_pkg.sv
// Types and the signed saturating clamp shared by the MAC accumulate stage.
// Clamp operands are carried at CLAMP_WIDTH bits so one function serves every width.
package mac_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int CLAMP_WIDTH = 64;

    typedef struct packed {
        logic signed [CLAMP_WIDTH-1:0] value;
        logic                          clamped;
    } clamp_t;

    // Clamps a sign-extended value into the signed range of 'width' bits.
    function automatic clamp_t sat_clamp(input logic signed [CLAMP_WIDTH-1:0] value,
                                         input int width);
        logic signed [CLAMP_WIDTH-1:0] max_val;
        logic signed [CLAMP_WIDTH-1:0] min_val;
        clamp_t r;
        max_val   = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_val   = -(64'sd1 <<< (width - 1));
        r.clamped = 1'b1;
        if (value > max_val) begin
            r.value = max_val;
        end else if (value < min_val) begin
            r.value = min_val;
        end else begin
            r.value   = value;
            r.clamped = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_narrow.sv
// Combinational clamp of the wide accumulator into the signed output range.
// No shifting happens here; any scaling is applied upstream of the multiplier.
module sat_narrow
    import mac_pkg::*;
#(
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_WIDTH-1:0] result,
    output logic                        clamped
);

    clamp_t                             narrow;
    logic [CLAMP_WIDTH-OUT_WIDTH-1:0]   unused_high;

    always_comb begin
        narrow = sat_clamp({{(CLAMP_WIDTH-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc}, OUT_WIDTH);
    end

    assign result      = narrow.value[OUT_WIDTH-1:0];
    assign clamped     = narrow.clamped;
    assign unused_high = narrow.value[CLAMP_WIDTH-1:OUT_WIDTH];

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates signed products into a saturating wide sum and emits one narrowed,
// saturated result per last-flagged term through a valid/ready handshake.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        arst_n_in,
    input  logic signed [IN_WIDTH-1:0]  prod_in,
    input  logic                        prod_valid_in,
    input  logic                        prod_last_in,
    output logic                        prod_ready_out,
    output logic signed [OUT_WIDTH-1:0] acc_out,
    output logic                        acc_valid_out,
    input  logic                        acc_ready_in,
    output logic                        overflow_out,
    output logic [CNT_WIDTH-1:0]        terms_out
);

    state_t                           state;
    state_t                           state_next;
    logic signed [ACC_WIDTH-1:0]      acc;
    logic signed [ACC_WIDTH-1:0]      acc_next;
    logic [CNT_WIDTH-1:0]             terms;
    logic [CNT_WIDTH-1:0]             terms_next;
    logic                             ovf;
    logic                             ovf_next;
    logic                             fresh;
    logic                             accept;
    logic                             out_fire;
    logic signed [ACC_WIDTH:0]        sum;
    clamp_t                           acc_clamp;
    logic [CLAMP_WIDTH-ACC_WIDTH-1:0] unused_acc_high;
    logic signed [OUT_WIDTH-1:0]      narrow;
    logic                             narrow_clamped;

    // A held result only blocks new products while downstream is stalled.
    assign prod_ready_out = (state == ACCUM) || acc_ready_in;
    assign acc_valid_out  = (state == HOLD);
    assign accept         = prod_valid_in && prod_ready_out;
    assign out_fire       = acc_valid_out && acc_ready_in;

    // One guard bit above ACC_WIDTH lets the clamp see the true sum.
    always_comb begin
        sum = {{(ACC_WIDTH+1-IN_WIDTH){prod_in[IN_WIDTH-1]}}, prod_in};
        if (!fresh) begin
            sum = sum + {acc[ACC_WIDTH-1], acc};
        end
        acc_clamp = sat_clamp({{(CLAMP_WIDTH-ACC_WIDTH-1){sum[ACC_WIDTH]}}, sum}, ACC_WIDTH);
        acc_next  = acc_clamp.value[ACC_WIDTH-1:0];
        ovf_next  = acc_clamp.clamped || (!fresh && ovf);
        if (fresh) begin
            terms_next = CNT_WIDTH'(1);
        end else if (&terms) begin
            terms_next = terms;
        end else begin
            terms_next = terms + CNT_WIDTH'(1);
        end
    end

    assign unused_acc_high = acc_clamp.value[CLAMP_WIDTH-1:ACC_WIDTH];

    sat_narrow #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat_narrow (
        .acc     (acc_next),
        .result  (narrow),
        .clamped (narrow_clamped)
    );

    always_comb begin
        state_next = state;
        if (accept && prod_last_in) begin
            state_next = HOLD;
        end else if (out_fire) begin
            state_next = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // 'fresh' marks that the next accepted term starts a new sum.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            acc          <= '0;
            terms        <= '0;
            ovf          <= 1'b0;
            fresh        <= 1'b1;
            acc_out      <= '0;
            overflow_out <= 1'b0;
            terms_out    <= '0;
        end else if (accept) begin
            acc   <= acc_next;
            terms <= terms_next;
            ovf   <= ovf_next;
            fresh <= prod_last_in;
            if (prod_last_in) begin
                acc_out      <= narrow;
                overflow_out <= ovf_next || narrow_clamped;
                terms_out    <= terms_next;
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a vector table for single-cycle behaviour plus
// hand-written sequences for backpressure, term saturation, reset and accumulator clamp.
module tb_mac_accumulator;

    typedef struct {
        logic               vld;
        logic signed [31:0] prod;
        logic               last;
        logic               exp_valid;
        logic signed [15:0] exp_acc;
        logic [7:0]         exp_terms;
        logic               exp_ovf;
    } vec_t;

    logic               clk;
    logic               arst_n;
    logic signed [31:0] prod;
    logic               prod_valid;
    logic               prod_last;
    logic               prod_ready;
    logic signed [15:0] acc;
    logic               acc_valid;
    logic               acc_ready;
    logic               ovf;
    logic [7:0]         terms;

    logic signed [31:0] prod_s;
    logic               prod_valid_s;
    logic               prod_last_s;
    logic               prod_ready_s;
    logic signed [15:0] acc_s;
    logic               acc_valid_s;
    logic               ovf_s;
    logic [7:0]         terms_s;

    int   total;
    int   bad;
    vec_t vecs[$];

    mac_accumulator dut (
        .clk            (clk),
        .arst_n_in      (arst_n),
        .prod_in        (prod),
        .prod_valid_in  (prod_valid),
        .prod_last_in   (prod_last),
        .prod_ready_out (prod_ready),
        .acc_out        (acc),
        .acc_valid_out  (acc_valid),
        .acc_ready_in   (acc_ready),
        .overflow_out   (ovf),
        .terms_out      (terms)
    );

    // Narrow accumulator so that the internal clamp is reachable with 32-bit terms.
    mac_accumulator #(.ACC_WIDTH(33)) dut_sat (
        .clk            (clk),
        .arst_n_in      (arst_n),
        .prod_in        (prod_s),
        .prod_valid_in  (prod_valid_s),
        .prod_last_in   (prod_last_s),
        .prod_ready_out (prod_ready_s),
        .acc_out        (acc_s),
        .acc_valid_out  (acc_valid_s),
        .acc_ready_in   (1'b1),
        .overflow_out   (ovf_s),
        .terms_out      (terms_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic signed [63:0] act,
                                input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic vld, input logic signed [31:0] p, input logic last);
        prod_valid = vld;
        prod       = p;
        prod_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_sat(input logic vld, input logic signed [31:0] p, input logic last);
        prod_valid_s = vld;
        prod_s       = p;
        prod_last_s  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic signed [15:0] e_acc,
                                input logic [7:0] e_terms, input logic e_ovf);
        check_output({tag, " valid"}, acc_valid, 1);
        check_output({tag, " acc"},   acc,       e_acc);
        check_output({tag, " terms"}, terms,     e_terms);
        check_output({tag, " ovf"},   ovf,       e_ovf);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        arst_n       = 1'b0;
        prod         = '0;
        prod_valid   = 1'b0;
        prod_last    = 1'b0;
        acc_ready    = 1'b1;
        prod_s       = '0;
        prod_valid_s = 1'b0;
        prod_last_s  = 1'b0;

        vecs.push_back('{1'b1,  32'sd100,    1'b0, 1'b0, 16'sd0,      8'd0, 1'b0});
        vecs.push_back('{1'b1, -32'sd30,     1'b0, 1'b0, 16'sd0,      8'd0, 1'b0});
        vecs.push_back('{1'b1,  32'sd7,      1'b1, 1'b1, 16'sd77,     8'd3, 1'b0});
        vecs.push_back('{1'b0,  32'sd999,    1'b1, 1'b0, 16'sd0,      8'd0, 1'b0});
        vecs.push_back('{1'b1,  32'sd30000,  1'b0, 1'b0, 16'sd0,      8'd0, 1'b0});
        vecs.push_back('{1'b1,  32'sd30000,  1'b1, 1'b1, 16'sd32767,  8'd2, 1'b1});
        vecs.push_back('{1'b1, -32'sd30000,  1'b0, 1'b0, 16'sd0,      8'd0, 1'b0});
        vecs.push_back('{1'b1, -32'sd30000,  1'b1, 1'b1, -16'sd32768, 8'd2, 1'b1});
        vecs.push_back('{1'b1,  32'sd1,      1'b1, 1'b1, 16'sd1,      8'd1, 1'b0});
        vecs.push_back('{1'b1,  32'sd2,      1'b1, 1'b1, 16'sd2,      8'd1, 1'b0});
        vecs.push_back('{1'b1,  32'sd3,      1'b1, 1'b1, 16'sd3,      8'd1, 1'b0});
        vecs.push_back('{1'b1,  32'sd32767,  1'b1, 1'b1, 16'sd32767,  8'd1, 1'b0});
        vecs.push_back('{1'b1, -32'sd32768,  1'b1, 1'b1, -16'sd32768, 8'd1, 1'b0});
        vecs.push_back('{1'b1,  32'sd32767,  1'b0, 1'b0, 16'sd0,      8'd0, 1'b0});
        vecs.push_back('{1'b1,  32'sd1,      1'b1, 1'b1, 16'sd32767,  8'd2, 1'b1});
        vecs.push_back('{1'b1, -32'sd5,      1'b0, 1'b0, 16'sd0,      8'd0, 1'b0});
        vecs.push_back('{1'b1, -32'sd3,      1'b1, 1'b1, -16'sd8,     8'd2, 1'b0});
        vecs.push_back('{1'b0,  32'sd0,      1'b0, 1'b0, 16'sd0,      8'd0, 1'b0});

        #2;
        check_output("reset acc",   acc,        0);
        check_output("reset valid", acc_valid,  0);
        check_output("reset terms", terms,      0);
        check_output("reset ovf",   ovf,        0);
        check_output("reset ready", prod_ready, 1);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].vld, vecs[i].prod, vecs[i].last);
            check_output($sformatf("vec%0d valid", i), acc_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check_output($sformatf("vec%0d acc", i),   acc,   vecs[i].exp_acc);
                check_output($sformatf("vec%0d terms", i), terms, vecs[i].exp_terms);
                check_output($sformatf("vec%0d ovf", i),   ovf,   vecs[i].exp_ovf);
            end
        end

        // Backpressure: result held, products blocked, then released.
        acc_ready = 1'b0;
        apply_stimulus(1'b1, 32'sd10, 1'b0);
        apply_stimulus(1'b1, 32'sd20, 1'b1);
        check_result("bp first", 16'sd30, 8'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 32'sd99, 1'b0);
            check_output($sformatf("bp stall%0d ready", i), prod_ready, 0);
            check_result($sformatf("bp stall%0d", i), 16'sd30, 8'd2, 1'b0);
        end
        acc_ready = 1'b1;
        #1;
        check_output("bp release ready", prod_ready, 1);
        apply_stimulus(1'b1, 32'sd99, 1'b1);
        check_result("bp new single", 16'sd99, 8'd1, 1'b0);
        acc_ready = 1'b0;
        apply_stimulus(1'b0, 32'sd0, 1'b0);
        check_output("bp hold valid", acc_valid, 1);
        acc_ready = 1'b1;
        apply_stimulus(1'b1, 32'sd4, 1'b0);
        check_output("bp fire to accum valid", acc_valid, 0);
        apply_stimulus(1'b1, 32'sd6, 1'b1);
        check_result("bp new pair", 16'sd10, 8'd2, 1'b0);
        apply_stimulus(1'b0, 32'sd0, 1'b0);
        check_output("bp drained valid", acc_valid, 0);

        // Term counter saturates at all-ones while the sum keeps growing.
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1'b1, 32'sd1, (i == 299));
        end
        check_result("terms sat", 16'sd300, 8'd255, 1'b0);
        apply_stimulus(1'b0, 32'sd0, 1'b0);

        // Asynchronous reset in the middle of a sum discards it.
        apply_stimulus(1'b1, 32'sd5, 1'b0);
        apply_stimulus(1'b1, 32'sd6, 1'b0);
        prod_valid = 1'b0;
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check_output("mid reset acc",   acc,        0);
        check_output("mid reset terms", terms,      0);
        check_output("mid reset valid", acc_valid,  0);
        check_output("mid reset ready", prod_ready, 1);
        #1;
        arst_n = 1'b1;
        apply_stimulus(1'b1, 32'sd5, 1'b1);
        check_result("after reset", 16'sd5, 8'd1, 1'b0);
        apply_stimulus(1'b0, 32'sd0, 1'b0);

        // 33-bit accumulator: clamp to 2^32-1 instead of wrapping.
        apply_sat(1'b1, 32'sh7fffffff, 1'b0);
        apply_sat(1'b1, 32'sh7fffffff, 1'b0);
        apply_sat(1'b1, 32'sh7fffffff, 1'b1);
        check_output("accsat valid", acc_valid_s, 1);
        check_output("accsat acc",   acc_s,       32767);
        check_output("accsat ovf",   ovf_s,       1);
        check_output("accsat terms", terms_s,     3);
        // Clamped sum 2^32-1 minus 2^32 lands at -1, overflow stays sticky.
        apply_sat(1'b1, 32'sh7fffffff, 1'b0);
        apply_sat(1'b1, 32'sh7fffffff, 1'b0);
        apply_sat(1'b1, 32'sh7fffffff, 1'b0);
        apply_sat(1'b1, 32'sh80000000, 1'b0);
        apply_sat(1'b1, 32'sh80000000, 1'b1);
        check_output("sticky valid", acc_valid_s, 1);
        check_output("sticky acc",   acc_s,       -1);
        check_output("sticky ovf",   ovf_s,       1);
        check_output("sticky terms", terms_s,     5);
        apply_sat(1'b0, 32'sd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
